// File: rtl/canny_pkg.sv
// Shared types and default geometry for the Canny pixel pipeline blocks.
package canny_pkg;

  localparam int unsigned DEF_PIX_W  = 8;
  localparam int unsigned DEF_IMG_W  = 512;
  localparam int unsigned DEF_IMG_H  = 512;
  localparam int unsigned DEF_ADDR_W = 18;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } wr_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_PIX_W-1:0]  data;
  } fifo_entry_t;

endpackage

// File: rtl/edge_frame_writer_if.sv
// Frame-memory write port: valid/ready with address and data.
interface edge_frame_writer_if
  import canny_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned PIX_W  = DEF_PIX_W
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;
  logic              mem_ready;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/edge_frame_writer_fifo.sv
// Synchronous FIFO with a registered head; push on full is accepted when a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_pop;
  logic             w_push;
  logic [PTR_W-1:0] w_rd_nxt;

  assign full     = (r_count == CNT_FULL);
  assign empty    = (r_count == '0);
  assign head     = r_head;
  assign w_pop    = pop && !empty;
  assign w_push   = push && (!full || w_pop);
  assign w_rd_nxt = r_rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Head mirrors r_mem[r_rd_ptr]; it is loaded from din when the incoming entry
  // becomes the head directly, otherwise from the next stored entry on pop.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
      if (w_push && (empty || (w_pop && r_count == CNT_ONE))) r_head <= din;
      else if (w_pop && r_count != CNT_ONE)                  r_head <= r_mem[w_rd_nxt];
    end
  end
endmodule

// File: rtl/edge_frame_writer.sv
// Captures one raster frame from a non-stalling pixel stream and writes it to
// frame memory through a stall-absorbing FIFO.
module edge_frame_writer
  import canny_pkg::*;
#(
  parameter int unsigned PIX_W      = DEF_PIX_W,
  parameter int unsigned IMG_W      = DEF_IMG_W,
  parameter int unsigned IMG_H      = DEF_IMG_H,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                frame_start,
  input  logic [PIX_W-1:0]    pixel_in,
  input  logic                pixel_in_valid,
  edge_frame_writer_if.master mem,
  output logic                busy,
  output logic                frame_done,
  output logic                overflow
);
  localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W+1)'(IMG_W * IMG_H - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } entry_t;

  wr_state_t       r_state;
  logic [ADDR_W:0] r_pix_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_ovf;

  entry_t w_entry;
  entry_t w_head;
  logic   w_full;
  logic   w_empty;
  logic   w_we;
  logic   w_pop;
  logic   w_cap_valid;

  assign w_cap_valid = (r_state == CAPTURE) && pixel_in_valid;
  assign w_we        = !w_empty;
  assign w_pop       = w_we && mem.mem_ready;
  assign w_entry     = '{addr: r_pix_cnt[ADDR_W-1:0], data: pixel_in};

  sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstN (rstN),
    .push (w_cap_valid),
    .pop  (w_pop),
    .din  (w_entry),
    .head (w_head),
    .full (w_full),
    .empty(w_empty)
  );

  assign mem.mem_we    = w_we;
  assign mem.mem_addr  = w_head.addr;
  assign mem.mem_wdata = w_head.data;
  assign busy          = r_busy;
  assign frame_done    = r_done;
  assign overflow      = r_ovf;

  // pix_cnt advances on every valid pixel, dropped or not, so addresses stay
  // locked to raster position even after an overflow.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= IDLE;
      r_pix_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_state   <= CAPTURE;
            r_pix_cnt <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        CAPTURE: begin
          if (pixel_in_valid) begin
            r_pix_cnt <= r_pix_cnt + (ADDR_W+1)'(1);
            if (w_full && !w_pop) r_ovf <= 1'b1;
            if (r_pix_cnt == LAST_PIX) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_empty) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
